// File: rtl/pipe_reg_ctrl.sv
// Pipeline register control: sequences flush bubbles, load-use stalls and
// LM/SM multi-cycle micro-ops, and drives Moore-decoded PC/pipe-reg enables.
module pipe_reg_ctrl (
    input  logic       CLK,
    input  logic       RST,
    input  logic       BRANCH_TAKEN,
    input  logic       MULTI_START,
    input  logic [7:0] REG_MASK,
    input  logic       LOAD_USE,
    output logic       WE_PC,
    output logic       WE_IFID,
    output logic       WE_IDEX,
    output logic       WE_EXMEM,
    output logic       WE_MEMWB,
    output logic       FLUSH_IFID,
    output logic       FLUSH_IDEX,
    output logic       MULTI_VALID,
    output logic [2:0] MULTI_IDX,
    output logic [7:0] STALL_COUNT
);

    typedef enum logic [1:0] {
        S_FLUSH,
        S_RUN,
        S_STALL,
        S_MULTI
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] mask_q, mask_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] mask_clr;
    logic [2:0] low_idx;
    logic       one_left;

    // Clearing the lowest set bit retires the current micro-op's register.
    assign mask_clr = mask_q & (mask_q - 8'd1);
    assign one_left = (mask_q != 8'd0) && (mask_clr == 8'd0);

    always_comb begin
        low_idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (mask_q[i]) low_idx = 3'(i);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_FLUSH;
            mask_q  <= 8'd0;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        unique case (state_q)
            S_FLUSH: state_d = BRANCH_TAKEN ? S_FLUSH : S_RUN;
            S_RUN: begin
                if (BRANCH_TAKEN) begin
                    state_d = S_FLUSH;
                end else if (MULTI_START && (REG_MASK != 8'd0)) begin
                    state_d = S_MULTI;
                    mask_d  = REG_MASK;
                end else if (LOAD_USE) begin
                    state_d = S_STALL;
                end
            end
            S_STALL: state_d = BRANCH_TAKEN ? S_FLUSH : S_RUN;
            S_MULTI: begin
                if (BRANCH_TAKEN) begin
                    state_d = S_FLUSH;
                    mask_d  = 8'd0;
                end else begin
                    mask_d  = mask_clr;
                    state_d = (mask_clr == 8'd0) ? S_RUN : S_MULTI;
                end
            end
            default: state_d = S_FLUSH;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (((state_q == S_STALL) || (state_q == S_MULTI)) && (cnt_q != 8'hFF))
            cnt_d = cnt_q + 8'd1;
    end

    always_comb begin
        WE_PC       = 1'b1;
        WE_IFID     = 1'b1;
        WE_IDEX     = 1'b1;
        WE_EXMEM    = 1'b1;
        WE_MEMWB    = 1'b1;
        FLUSH_IFID  = 1'b0;
        FLUSH_IDEX  = 1'b0;
        MULTI_VALID = 1'b0;
        MULTI_IDX   = 3'd0;
        unique case (state_q)
            S_FLUSH: begin
                FLUSH_IFID = 1'b1;
                FLUSH_IDEX = 1'b1;
            end
            S_RUN: ;
            S_STALL: begin
                WE_PC      = 1'b0;
                WE_IFID    = 1'b0;
                FLUSH_IDEX = 1'b1;
            end
            S_MULTI: begin
                // Fetch resumes only on the final micro-op of the sequence.
                WE_PC       = one_left;
                WE_IFID     = one_left;
                MULTI_VALID = 1'b1;
                MULTI_IDX   = low_idx;
            end
            default: ;
        endcase
    end

    assign STALL_COUNT = cnt_q;

endmodule

// File: doc/pipe_reg_ctrl.md
PIPE_REG_CTRL -- requirements
Module: pipe_reg_ctrl

Interface
REQ-001 The block SHALL have one clock and synchronous, active-high reset, with ports as follows.
REQ-002 CLK  in  1  rising-edge clock for all state.
REQ-003 RST  in  1  synchronous, active-high reset, sampled on the CLK rising edge.
REQ-004 BRANCH_TAKEN  in  1  taken branch/jump resolved in EX.
REQ-005 MULTI_START  in  1  LM/SM instruction in ID requests multi-cycle sequencing.
REQ-006 REG_MASK  in  8  LM/SM register mask; bit i selects register Ri.
REQ-007 LOAD_USE  in  1  load-use hazard detected in ID.
REQ-008 WE_PC, WE_IFID, WE_IDEX, WE_EXMEM, WE_MEMWB  out  1 each  write enables to the PC and pipeline registers.
REQ-009 FLUSH_IFID, FLUSH_IDEX  out  1 each  bubble insertion into IF/ID and ID/EX.
REQ-010 MULTI_VALID  out  1  the current cycle carries an LM/SM micro-op.
REQ-011 MULTI_IDX  out  3  register index of the current LM/SM micro-op.
REQ-012 STALL_COUNT  out  8  saturating count of stall or multi cycles.

Function
REQ-013 States SHALL be FLUSH, RUN, STALL and MULTI, held in a state register updated on the CLK rising edge.
REQ-014 All outputs SHALL be decoded from the state register and the mask register only (Moore); an input sampled at edge N affects outputs after edge N.
REQ-015 FLUSH outputs SHALL be: all WE=1, FLUSH_IFID=1, FLUSH_IDEX=1, MULTI_VALID=0, MULTI_IDX=0.
REQ-016 RUN outputs SHALL be: all WE=1, both FLUSH=0, MULTI_VALID=0, MULTI_IDX=0.
REQ-017 STALL outputs SHALL be: WE_PC=0, WE_IFID=0, FLUSH_IDEX=1, and all other WE=1.
REQ-018 MULTI outputs SHALL be:
  - MULTI_VALID=1 and MULTI_IDX = index of the lowest set bit of MASK_REG.
  - WE_IDEX, WE_EXMEM and WE_MEMWB = 1, both FLUSH=0.
  - WE_PC and WE_IFID = 0 while MASK_REG has more than one bit set, and 1 when exactly one bit is set.
REQ-019 Next state from FLUSH SHALL be RUN, unless BRANCH_TAKEN=1, in which case it SHALL be FLUSH.
REQ-020 Next state from RUN SHALL be chosen by this priority:
  - BRANCH_TAKEN -> FLUSH.
  - MULTI_START with REG_MASK != 0 -> MULTI, latching MASK_REG <= REG_MASK.
  - LOAD_USE -> STALL.
  - Otherwise RUN.
REQ-021 MULTI_START with REG_MASK == 0 SHALL be a no-op: state stays RUN and MASK_REG is unchanged.
REQ-022 STALL SHALL last exactly one cycle; the next state is FLUSH if BRANCH_TAKEN=1, otherwise RUN.
REQ-023 LOAD_USE and MULTI_START sampled while in STALL SHALL be ignored.
REQ-024 In MULTI, each edge SHALL clear the lowest set bit of MASK_REG and SHALL return to RUN when the cleared result is 0.
REQ-025 BRANCH_TAKEN=1 in MULTI SHALL abort sequencing: next state FLUSH, MASK_REG <= 0.
REQ-026 MULTI_START and LOAD_USE sampled in MULTI SHALL be ignored.
REQ-027 STALL_COUNT SHALL increment by 1 on each edge where the current state is STALL or MULTI, and SHALL saturate at 255 with no wrap.

Reset
REQ-028 RST=1 at an edge SHALL force state FLUSH, MASK_REG=0 and STALL_COUNT=0, overriding all other inputs, including mid-MULTI and mid-STALL.
REQ-029 After reset, outputs SHALL be the FLUSH values (all WE=1, both FLUSH=1, MULTI_VALID=0, MULTI_IDX=0, STALL_COUNT=0) until the first non-reset edge.

Verification
REQ-030 Reset, then one idle cycle -> one FLUSH cycle, then RUN with all WE=1 and FLUSH=0.
REQ-031 LOAD_USE=1 for 3 consecutive cycles in RUN:
  - Response: STALL for 1 cycle (WE_PC=0, WE_IFID=0, FLUSH_IDEX=1), then RUN, then STALL again.
  - STALL_COUNT=2 afterwards.
REQ-032 MULTI_START with REG_MASK=8'b1010_0100:
  - MULTI_IDX sequence 2, 5, 7 with MULTI_VALID=1 for 3 cycles.
  - WE_PC=0 for the first 2 cycles and 1 on the 3rd, then RUN.
  - STALL_COUNT=3.
REQ-033 BRANCH_TAKEN=1, MULTI_START=1 and LOAD_USE=1 in the same RUN cycle -> FLUSH only; MASK_REG stays 0.
REQ-034 BRANCH_TAKEN=1 during the 2nd MULTI cycle of mask 8'hFF:
  - Response: FLUSH next cycle, MULTI_VALID=0, then RUN.
  - A later MULTI_START with mask 8'h01 yields MULTI_IDX=0 for exactly 1 cycle.
REQ-035 RST=1 mid-MULTI with mask 8'hF0 and STALL_COUNT=255 -> FLUSH state, STALL_COUNT=0, MULTI_VALID=0; MULTI_START with REG_MASK=0 afterwards -> stays RUN.
